// File: rtl/d_flip_flop_opt.sv
// Positive-edge D flip-flop with complemented output and async active-low reset.
// Define DFF_SYNC_EN to turn it into a SYNC_STAGES-deep clock-domain synchroniser.
`timescale 1ns/100ps

module d_flip_flop_opt #(
  parameter int                WIDTH       = 1,
  parameter logic [WIDTH-1:0]  RESET_VALUE = {WIDTH{1'b0}},
  parameter int                SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);

`ifdef DFF_SYNC_EN
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_stages_check
    $error("d_flip_flop_opt: SYNC_STAGES must be in 2..4");
  end

  // Leading stages of the chain; q_reg is the final stage driving q and qbar.
  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] stage_reg [SYNC_STAGES-1];
  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] q_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES - 1; i++) begin
        stage_reg[i] <= RESET_VALUE;
      end
      q_reg <= RESET_VALUE;
    end else begin
      stage_reg[0] <= d;
      for (int i = 1; i < SYNC_STAGES - 1; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
      q_reg <= stage_reg[SYNC_STAGES-2];
    end
  end
`else
  logic [WIDTH-1:0] q_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= RESET_VALUE;
    end else begin
      q_reg <= d;
    end
  end
`endif

  // qbar is an inversion of the same register so q and qbar can never disagree.
  assign q    = q_reg;
  assign qbar = ~q_reg;

endmodule

// File: tb/tb_d_flip_flop_opt.sv
// Scoreboard bench for d_flip_flop_opt: a 1-bit and an 8-bit (reset 8'hA5) instance
// checked against a delay-line reference model; latency follows DFF_SYNC_EN.
`timescale 1ns/100ps

module tb_d_flip_flop_opt;

`ifdef DFF_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  localparam logic [7:0] RV8 = 8'hA5;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       d1    = 1'b0;
  logic [7:0] d8    = 8'h00;
  logic       q1, qbar1;
  logic [7:0] q8, qbar8;

  int tests = 0;
  int fails = 0;

  // Reference model state: values captured since the last reset (newest first)
  logic       hist1 [$];
  logic [7:0] hist8 [$];
  logic       exp1_q [$];
  logic [7:0] exp8_q [$];

  d_flip_flop_opt #(.WIDTH(1), .RESET_VALUE(1'b0), .SYNC_STAGES(3)) u_dff1 (
    .clk(clk), .rst_n(rst_n), .d(d1), .q(q1), .qbar(qbar1)
  );

  d_flip_flop_opt #(.WIDTH(8), .RESET_VALUE(RV8), .SYNC_STAGES(3)) u_dff8 (
    .clk(clk), .rst_n(rst_n), .d(d8), .q(q8), .qbar(qbar8)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reset wipes the captured history whenever it falls, with or without a clock.
  always @(negedge rst_n) begin
    hist1.delete();
    hist8.delete();
  end

  // Model: q after an edge is d from LAT-1 edges earlier, or the reset value
  // if fewer than LAT captures have happened since reset.
  always @(posedge clk) begin
    if (rst_n !== 1'b1) begin
      hist1.delete();
      hist8.delete();
      exp1_q.push_back(1'b0);
      exp8_q.push_back(RV8);
    end else begin
      hist1.push_front(d1);
      hist8.push_front(d8);
      if (hist1.size() > LAT) void'(hist1.pop_back());
      if (hist8.size() > LAT) void'(hist8.pop_back());
      exp1_q.push_back(hist1.size() >= LAT ? hist1[LAT-1] : 1'b0);
      exp8_q.push_back(hist8.size() >= LAT ? hist8[LAT-1] : RV8);
    end
  end

  // Monitor: one transaction per rising edge, compared 1 ns after the edge.
  always @(posedge clk) begin
    logic       e1;
    logic [7:0] e8;
    #1;
    if (exp1_q.size() == 0 || exp8_q.size() == 0) begin
      check("sb_empty", 8'd0, 8'd1);
    end else begin
      e1 = exp1_q.pop_front();
      e8 = exp8_q.pop_front();
      $display("[TB] t=%0t rst_n=%b q1=%b/%b qbar1=%b q8=%h/%h qbar8=%h",
               $time, rst_n, q1, e1, qbar1, q8, e8, qbar8);
      check("q1",    {7'd0, q1},    {7'd0, e1});
      check("qbar1", {7'd0, qbar1}, {7'd0, ~e1});
      check("q8",    q8,            e8);
      check("qbar8", qbar8,         ~e8);
    end
  end

  initial begin
    // Reset applied with no clock edge yet: outputs must load immediately.
    #1 rst_n = 1'b0;
    #0.5;
    check("rst_async_q1",    {7'd0, q1},    8'd0);
    check("rst_async_qbar1", {7'd0, qbar1}, 8'd1);
    check("rst_async_q8",    q8,            8'hA5);
    check("rst_async_qbar8", qbar8,         8'h5A);

    // Hold reset with d = 1 across three edges.
    d1 = 1'b1;
    d8 = 8'hFF;
    repeat (3) @(posedge clk);
    #2;
    check("rst_hold_q1", {7'd0, q1}, 8'd0);
    check("rst_hold_q8", q8,         8'hA5);

    // Release away from an edge, then capture d = 1 / 8'h3C.
    @(negedge clk);
    rst_n = 1'b0;
    rst_n = 1'b1;
    d8    = 8'h3C;
    repeat (LAT) @(posedge clk);
    #2;
    check("release_q1",    {7'd0, q1}, 8'd1);
    check("release_q8",    q8,         8'h3C);
    check("release_qbar8", qbar8,      8'hC3);

    // Mid-cycle reset with clk high: q must clear without another edge.
    rst_n = 1'b0;
    #0.1;
    check("midcycle_rst_q1",    {7'd0, q1},    8'd0);
    check("midcycle_rst_qbar1", {7'd0, qbar1}, 8'd1);
    check("midcycle_rst_q8",    q8,            8'hA5);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Glitch immunity: d pulses high between two edges only.
    d1 = 1'b0;
    d8 = 8'h00;
    repeat (LAT + 1) @(posedge clk);
    #2 d1 = 1'b1; d8 = 8'hFF;
    #2 d1 = 1'b0; d8 = 8'h00;
    check("glitch_q1", {7'd0, q1}, 8'd0);
    check("glitch_q8", q8,         8'h00);
    repeat (LAT + 1) @(posedge clk);

    // Step test: d rises just before an edge and stays high.
    @(negedge clk);
    d1 = 1'b1;
    repeat (LAT + 2) @(posedge clk);

    // Free-running: d toggles every 13 ns, offset so it never lands on an edge.
    @(posedge clk);
    #1.5;
    repeat (77) begin
      d1 = ~d1;
      d8 = 8'($urandom);
      #13;
    end

    // Random data with occasional reset pulses that span one edge.
    repeat (200) begin
      @(negedge clk);
      d1 = 1'($urandom);
      d8 = 8'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    repeat (2) @(posedge clk);
    #3;
    check("sb_drained", 8'(exp1_q.size() + exp8_q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
